// File: rtl/pleiads_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pleiads_pkg
//  Description : Shared constants and types for the Pleiads ROM loader:
//                region map, default image size, FSM and region encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pleiads_pkg;

  // Region map of the downloaded image (byte addresses)
  localparam logic [24:0] c_prog_base = 25'h0000;
  localparam logic [24:0] c_prog_size = 25'h4000;
  localparam logic [24:0] c_bg_base   = 25'h4000;
  localparam logic [24:0] c_bg_size   = 25'h1000;
  localparam logic [24:0] c_fg_base   = 25'h5000;
  localparam logic [24:0] c_fg_size   = 25'h1000;
  localparam logic [24:0] c_prom_base = 25'h6000;
  localparam logic [24:0] c_prom_size = 25'h0200;

  // Total image length expected from the downloader
  localparam int c_rom_size_default = 25088;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    REGION_NONE = 3'd0,
    REGION_PROG = 3'd1,
    REGION_BG   = 3'd2,
    REGION_FG   = 3'd3,
    REGION_PROM = 3'd4
  } region_t;

  // One-hot strobe vector {prog, bg, fg, prom} for a decoded region
  function automatic logic [3:0] region_strobes(input region_t region);
    logic [3:0] strobes;
    strobes = 4'b0000;
    case (region)
      REGION_PROG: strobes = 4'b1000;
      REGION_BG:   strobes = 4'b0100;
      REGION_FG:   strobes = 4'b0010;
      REGION_PROM: strobes = 4'b0001;
      default:     strobes = 4'b0000;
    endcase
    return strobes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pleiads_rom_decode.sv
`default_nettype none
// ============================================================================
//  Module      : pleiads_rom_decode
//  Description : Combinational address decoder: maps an image byte address
//                to a target region and the address local to that region.
//  Revision    : 1.0 - initial release
// ============================================================================
module pleiads_rom_decode
  import pleiads_pkg::*;
(
  input  logic [24:0] dn_addr,
  output region_t     region,
  output logic [13:0] local_addr
);

  // Range compare against the region map; anything past PROM is unmapped
  always_comb begin
    region     = REGION_NONE;
    local_addr = 14'd0;
    if (dn_addr < c_prog_base + c_prog_size) begin
      region     = REGION_PROG;
      local_addr = 14'(dn_addr - c_prog_base);
    end else if (dn_addr < c_bg_base + c_bg_size) begin
      region     = REGION_BG;
      local_addr = 14'(dn_addr - c_bg_base);
    end else if (dn_addr < c_fg_base + c_fg_size) begin
      region     = REGION_FG;
      local_addr = 14'(dn_addr - c_fg_base);
    end else if (dn_addr < c_prom_base + c_prom_size) begin
      region     = REGION_PROM;
      local_addr = 14'(dn_addr - c_prom_base);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pleiads_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pleiads_rom_loader
//  Description : Receives the streamed ROM image, steers each byte to the
//                program / background / foreground / PROM memories, checks
//                the image length and releases the game core from reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module pleiads_rom_loader
  import pleiads_pkg::*;
#(
  parameter int ROM_SIZE    = c_rom_size_default,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        prog_we,
  output logic        bg_we,
  output logic        fg_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [7:0]  checksum
);

  localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_dl_d;
  logic                w_dl_rise;
  logic                w_accept;
  logic                w_load_entry;
  logic                w_count_match;
  logic                w_hold_done;
  region_t             w_region;
  logic [13:0]         w_local_addr;
  logic [15:0]         r_count;
  logic [7:0]          r_checksum;
  logic                r_load_ok;
  logic                r_load_err;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [3:0]          r_we;
  logic [13:0]         r_wr_addr;
  logic [7:0]          r_wr_data;

  pleiads_rom_decode u_decode (
    .dn_addr    (dn_addr),
    .region     (w_region),
    .local_addr (w_local_addr)
  );

  assign w_dl_rise     = dn_download & ~r_dl_d;
  assign w_accept      = (r_state == ST_LOAD) & dn_wr;
  assign w_load_entry  = (w_state_next == ST_LOAD) & (r_state != ST_LOAD);
  assign w_count_match = (r_count == 16'(ROM_SIZE));
  assign w_hold_done   = (r_hold_cnt == c_hold_w'(HOLD_CYCLES - 1));

  // Registered copy of dn_download for edge detection; resets high so a
  // level already high when reset releases is not mistaken for a rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dl_d <= 1'b1;
    else          r_dl_d <= dn_download;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; a new download rise restarts from any settled state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_dl_rise) w_state_next = ST_LOAD;
      ST_LOAD:  if (!dn_download) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = w_count_match ? ST_HOLD : ST_ERROR;
      ST_HOLD: begin
        if (w_dl_rise)        w_state_next = ST_LOAD;
        else if (w_hold_done) w_state_next = ST_RUN;
      end
      ST_RUN:   if (w_dl_rise) w_state_next = ST_LOAD;
      ST_ERROR: if (w_dl_rise) w_state_next = ST_LOAD;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Byte count (saturating) and running mod-256 checksum of accepted bytes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= 16'd0;
      r_checksum <= 8'd0;
    end else if (w_load_entry) begin
      r_count    <= 16'd0;
      r_checksum <= 8'd0;
    end else if (w_accept) begin
      if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      r_checksum <= r_checksum + dn_data;
    end
  end

  // Result flags: cleared when a load starts, decided once in CHECK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_ok  <= 1'b0;
      r_load_err <= 1'b0;
    end else if (w_load_entry) begin
      r_load_ok  <= 1'b0;
      r_load_err <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_load_ok  <= w_count_match;
      r_load_err <= ~w_count_match;
    end
  end

  // Hold timer; restarts from zero every time HOLD is entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_hold_cnt <= '0;
    else if (r_state != ST_HOLD) r_hold_cnt <= '0;
    else if (!w_hold_done)      r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  // Registered write port: one strobe per accepted in-map byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we      <= 4'b0000;
      r_wr_addr <= 14'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_we <= 4'b0000;
      if (w_accept) begin
        r_we      <= region_strobes(w_region);
        r_wr_addr <= w_local_addr;
        r_wr_data <= dn_data;
      end
    end
  end

  assign prog_we    = r_we[3];
  assign bg_we      = r_we[2];
  assign fg_we      = r_we[1];
  assign prom_we    = r_we[0];
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign checksum   = r_checksum;
  assign load_ok    = r_load_ok;
  assign load_err   = r_load_err;
  assign core_reset = (r_state != ST_RUN);

endmodule
`default_nettype wire
